// File: rtl/z_core_pkg.sv
// Shared constants for the z_core memory arbiter: FSM state encodings, master ids
// and the word-address range test used when a request is issued.
package z_core_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

  // A word address is in range when no bit above the RAM index is set.
  function automatic logic word_in_range(input logic [29:0] word, input int addr_w);
    return (word >> addr_w) == 30'd0;
  endfunction

endpackage

// File: rtl/z_core_rr_arbiter.sv
// Two-way request arbiter: combinational grant plus a round-robin pointer that
// moves to the losing master on every accepted request.
module z_core_rr_arbiter
  import z_core_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       fixed_prio,
  input  logic       accept,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (fixed_prio || rr_ptr == M0_ID) ? 2'b01 : 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= M0_ID;
    end else if (accept) begin
      rr_ptr <= grant[0] ? M1_ID : M0_ID;
    end
  end

endmodule

// File: rtl/z_core_mem_arbiter.sv
// Shares one single-port synchronous RAM between the z_core control unit (M0) and
// the debug/loader port (M1); one outstanding transaction, pulsed responses.
module z_core_mem_arbiter
  import z_core_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [3:0]        m0_req_wstrb,
  input  logic [31:0]       m0_req_addr,
  input  logic [31:0]       m0_req_wdata,
  output logic              m0_resp_valid,
  output logic [31:0]       m0_resp_rdata,
  output logic              m0_resp_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [3:0]        m1_req_wstrb,
  input  logic [31:0]       m1_req_addr,
  input  logic [31:0]       m1_req_wdata,
  output logic              m1_resp_valid,
  output logic [31:0]       m1_resp_rdata,
  output logic              m1_resp_err,

  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [1:0]       state;
  logic [1:0]       grant;
  logic             idle;
  logic             accept;
  logic             sel_id;
  logic             in_range;
  logic             resp_live;
  logic [CNT_W-1:0] lat_cnt;

  logic             id_q;
  logic             we_q;
  logic [3:0]       wstrb_q;
  logic [29:0]      word_q;
  logic [31:0]      wdata_q;

  logic [1:0][31:0] rdata_q;
  logic [1:0]       err_q;

  // Byte offset within a word never reaches the RAM.
  logic             unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_req_addr[1:0], m1_req_addr[1:0]};

  z_core_rr_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .valid      ({m1_req_valid, m0_req_valid}),
    .fixed_prio (FIXED_PRIO != 0),
    .accept     (accept),
    .grant      (grant)
  );

  // Reset is synchronous, so the strobes are also masked while it is held.
  assign idle         = (state == ST_IDLE) && !reset;
  assign m0_req_ready = idle && grant[0];
  assign m1_req_ready = idle && grant[1];
  assign accept       = (m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready);
  assign sel_id       = grant[1] ? M1_ID : M0_ID;
  assign in_range     = word_in_range(word_q, ADDR_W);

  // NOTE: request latches have no reset; they are only read after a handshake reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_q <= sel_id;
      if (sel_id == M1_ID) begin
        we_q    <= m1_req_we;
        wstrb_q <= m1_req_wstrb;
        word_q  <= m1_req_addr[31:2];
        wdata_q <= m1_req_wdata;
      end else begin
        we_q    <= m0_req_we;
        wstrb_q <= m0_req_wstrb;
        word_q  <= m0_req_addr[31:2];
        wdata_q <= m0_req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!in_range) begin
            rdata_q[id_q] <= '0;
            err_q[id_q]   <= 1'b1;
            state         <= ST_RESP;
          end else begin
            lat_cnt <= CNT_W'(MEM_LATENCY - 1);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            rdata_q[id_q] <= we_q ? 32'd0 : mem_rdata;
            err_q[id_q]   <= 1'b0;
            state         <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ST_ISSUE) && in_range && !reset;
  assign mem_we    = mem_en && we_q;
  assign mem_wstrb = mem_we ? wstrb_q : 4'b0000;
  assign mem_addr  = word_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;

  assign resp_live     = (state == ST_RESP) && !reset;
  assign m0_resp_valid = resp_live && (id_q == M0_ID);
  assign m1_resp_valid = resp_live && (id_q == M1_ID);
  assign m0_resp_rdata = rdata_q[0];
  assign m1_resp_rdata = rdata_q[1];
  assign m0_resp_err   = err_q[0];
  assign m1_resp_err   = err_q[1];

endmodule
